fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer between the PC and the combinational instruction memory.

---
 rtl/fetch_ctrl_if.sv | 50 +++++
 rtl/fetch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundles the fetch sequencer's bus signals: the instruction-memory address
//   and data pair, the decode-side valid/ready slot, the branch redirect
//   request, and the start/halt control pair.
//   Signal suffixes are taken from the fetch_ctrl side (_pi into fetch_ctrl,
//   _po out of fetch_ctrl).
//
// Modports
//   master : fetch_ctrl side (drives PC, slot and halt status)
//   slave  : environment side (memory, decode, branch unit, start control)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
    logic        start_pi;
    logic [15:0] imem_pc_po;
    logic [15:0] imem_instr_pi;
    logic [15:0] instr_po;
    logic [15:0] instr_pc_po;
    logic        instr_valid_po;
    logic        instr_ready_pi;
    logic        redirect_pi;
    logic [15:0] redirect_pc_pi;
    logic        halted_po;

    modport master (
        input  start_pi,
        output imem_pc_po,
        input  imem_instr_pi,
        output instr_po,
        output instr_pc_po,
        output instr_valid_po,
        input  instr_ready_pi,
        input  redirect_pi,
        input  redirect_pc_pi,
        output halted_po
    );

    modport slave (
        output start_pi,
        input  imem_pc_po,
        output imem_instr_pi,
        input  instr_po,
        input  instr_pc_po,
        input  instr_valid_po,
        output instr_ready_pi,
        output redirect_pi,
        output redirect_pc_pi,
        input  halted_po
    );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer sitting between the PC and a combinational
//   instruction memory. Owns the PC (driven straight out as the memory
//   address), registers each returned word into a one-entry valid/ready slot
//   for decode, and handles stall, branch redirect (flush) and HALT detection.
//
// Ports
//   clk_pi          in   clock, all state updates on posedge
//   reset_pi        in   synchronous active-high reset
//   bus             fetch_ctrl_if.master:
//                     start_pi, imem_pc_po, imem_instr_pi, instr_po,
//                     instr_pc_po, instr_valid_po, instr_ready_pi,
//                     redirect_pi, redirect_pc_pi, halted_po
//   fetch_count_po  out  captures performed (FETCH_PERF_EN only, saturating)
//   stall_count_po  out  FETCH cycles with valid & !ready (FETCH_PERF_EN only)
//
// Configuration
//   FETCH_PERF_EN   when defined, adds the two saturating perf counters and
//                   the CNT_W parameter; otherwise neither exists.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int unsigned PC_STEP     = 2,
    parameter logic [15:0] HALT_OPCODE = 16'hFFFF
`ifdef FETCH_PERF_EN
   ,parameter int unsigned CNT_W       = 16
`endif
) (
    input  logic              clk_pi,
    input  logic              reset_pi,
    fetch_ctrl_if.master      bus
`ifdef FETCH_PERF_EN
   ,output logic [CNT_W-1:0]  fetch_count_po
   ,output logic [CNT_W-1:0]  stall_count_po
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;

    logic        slot_free;
    logic        capture;
    logic        word_is_halt;

    // Next-state logic. Redirect outranks everything in FETCH; an accept on
    // the same edge still completes because decode sampled valid & ready.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        halted_d   = halted_q;

        slot_free    = !valid_q || bus.instr_ready_pi;
        word_is_halt = (bus.imem_instr_pi == HALT_OPCODE);
        capture      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start_pi) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (bus.redirect_pi) begin
                    // Target is halfword aligned; bit 0 is discarded.
                    pc_d    = bus.redirect_pc_pi & 16'hFFFE;
                    valid_d = 1'b0;
                end else if (slot_free) begin
                    capture    = 1'b1;
                    instr_d    = bus.imem_instr_pi;
                    instr_pc_d = pc_q;
                    valid_d    = 1'b1;
                    if (word_is_halt) begin
                        // PC stays on the HALT word so the address is frozen.
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 16'(PC_STEP);
                    end
                end
            end

            ST_HALT: begin
                if (valid_q && bus.instr_ready_pi) begin
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 16'h0000;
            instr_pc_q <= 16'h0000;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.imem_pc_po     = pc_q;
    assign bus.instr_po       = instr_q;
    assign bus.instr_pc_po    = instr_pc_q;
    assign bus.instr_valid_po = valid_q;
    assign bus.halted_po      = halted_q;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             stall_event;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        stall_event = (state_q == ST_FETCH) && valid_q && !bus.instr_ready_pi;
        fetch_cnt_d = capture     ? sat_inc(fetch_cnt_q) : fetch_cnt_q;
        stall_cnt_d = stall_event ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count_po = fetch_cnt_q;
    assign stall_count_po = stall_cnt_q;
`else
    // Capture strobe only feeds the perf counters.
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    fetch_ctrl_if bus ();

`ifdef FETCH_PERF_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    fetch_ctrl dut (
        .clk_pi   (clk),
        .reset_pi (rst),
        .bus      (bus)
`ifdef FETCH_PERF_EN
       ,.fetch_count_po (fetch_count)
       ,.stall_count_po (stall_count)
`endif
    );

    // Combinational instruction memory, indexed by halfword.
    logic [15:0] mem [32768];
    always_comb bus.imem_instr_pi = mem[bus.imem_pc_po[15:1]];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: program counter, a one-deep slot, and two flags that
    // say whether fetching has begun and whether a HALT word was taken.
    logic        m_started, m_halted, m_v;
    logic [15:0] m_pc, m_instr, m_ipc;
`ifdef FETCH_PERF_EN
    logic [15:0] m_fc, m_sc;
    function automatic logic [15:0] sat16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
`endif

    task automatic model_step();
        logic [15:0] w;
        if (rst) begin
            m_started = 1'b0; m_halted = 1'b0; m_v = 1'b0;
            m_pc = RESET_PC; m_instr = 16'h0; m_ipc = 16'h0;
`ifdef FETCH_PERF_EN
            m_fc = 16'h0; m_sc = 16'h0;
`endif
            return;
        end
        if (!m_started) begin
            if (bus.start_pi) m_started = 1'b1;
            return;
        end
        if (m_halted) begin
            if (m_v && bus.instr_ready_pi) m_v = 1'b0;
            return;
        end
`ifdef FETCH_PERF_EN
        if (m_v && !bus.instr_ready_pi) m_sc = sat16(m_sc);
`endif
        if (bus.redirect_pi) begin
            m_v  = 1'b0;
            m_pc = {bus.redirect_pc_pi[15:1], 1'b0};
        end else if (!m_v || bus.instr_ready_pi) begin
            w       = mem[m_pc[15:1]];
            m_v     = 1'b1;
            m_instr = w;
            m_ipc   = m_pc;
`ifdef FETCH_PERF_EN
            m_fc = sat16(m_fc);
`endif
            if (w == HALT_WORD) m_halted = 1'b1;
            else                m_pc = m_pc + 16'd2;
        end
    endtask

    task automatic compare();
        check("imem_pc", 32'(bus.imem_pc_po), 32'(m_pc));
        check("valid", 32'(bus.instr_valid_po), 32'(m_v));
        check("halted", 32'(bus.halted_po), 32'(m_halted));
        if (m_v) begin
            check("instr", 32'(bus.instr_po), 32'(m_instr));
            check("instr_pc", 32'(bus.instr_pc_po), 32'(m_ipc));
        end
`ifdef FETCH_PERF_EN
        check("fetch_count", 32'(fetch_count), 32'(m_fc));
        check("stall_count", 32'(stall_count), 32'(m_sc));
`endif
    endtask

    // One clock: compare at the falling edge, advance the model with the
    // inputs in force, then return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic rdy, input logic rd, input logic [15:0] rpc);
        bus.start_pi       = s;
        bus.instr_ready_pi = rdy;
        bus.redirect_pi    = rd;
        bus.redirect_pc_pi = rpc;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i & 32'h7FFF);
        drive(1'b0, 1'b1, 1'b0, 16'h0);

        // Initial reset: model follows without comparing unknown outputs.
        rst = 1'b1;
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // T1: reset values, then 3004 / 3200 / HALT on consecutive cycles.
        check("rst instr", 32'(bus.instr_po), 32'h0);
        check("rst instr_pc", 32'(bus.instr_pc_po), 32'h0);
        check("rst valid", 32'(bus.instr_valid_po), 32'h0);
        check("rst halted", 32'(bus.halted_po), 32'h0);
        check("rst pc", 32'(bus.imem_pc_po), 32'(RESET_PC));
        mem[0] = 16'h3004; mem[1] = 16'h3200; mem[2] = HALT_WORD;
        drive(1'b1, 1'b1, 1'b0, 16'h0); cycle();
        drive(1'b0, 1'b1, 1'b0, 16'h0); cycle();
        check("T1 w0", 32'(bus.instr_po), 32'h3004);
        check("T1 pc0", 32'(bus.instr_pc_po), 32'h0000);
        cycle();
        check("T1 w1", 32'(bus.instr_po), 32'h3200);
        check("T1 pc1", 32'(bus.instr_pc_po), 32'h0002);
        cycle();
        check("T1 w2", 32'(bus.instr_po), 32'hFFFF);
        check("T1 pc2", 32'(bus.instr_pc_po), 32'h0004);
        check("T1 halted", 32'(bus.halted_po), 32'h1);
        drive(1'b1, 1'b1, 1'b1, 16'h0040); cycle(); cycle();
        check("T1 pc held", 32'(bus.imem_pc_po), 32'h0004);
        check("T1 still halted", 32'(bus.halted_po), 32'h1);
        check("T1 drained", 32'(bus.instr_valid_po), 32'h0);
        for (int i = 0; i < 3; i++) mem[i] = 16'(i);

        // T2: stall with the pc-6 word in the slot.
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        rst = 1'b1; cycle(); rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 16'h0); cycle();
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 4; i++) cycle();
        check("T2 pc6", 32'(bus.instr_pc_po), 32'h0006);
        drive(1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 3; i++) cycle();
        check("T2 hold instr", 32'(bus.instr_po), 32'(mem[3]));
        check("T2 hold instr_pc", 32'(bus.instr_pc_po), 32'h0006);
        check("T2 hold imem_pc", 32'(bus.imem_pc_po), 32'h0008);
        drive(1'b0, 1'b1, 1'b0, 16'h0); cycle();
        check("T2 pc8", 32'(bus.instr_pc_po), 32'h0008);
`ifdef FETCH_PERF_EN
        check("T2 stall_count", 32'(stall_count), 32'd3);
`endif

        // T3: redirect to an odd target.
        drive(1'b0, 1'b1, 1'b1, 16'h0007); cycle();
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        check("T3 flushed", 32'(bus.instr_valid_po), 32'h0);
        check("T3 target", 32'(bus.imem_pc_po), 32'h0006);
        cycle();
        check("T3 valid", 32'(bus.instr_valid_po), 32'h1);
        check("T3 instr_pc", 32'(bus.instr_pc_po), 32'h0006);

        // T4: redirect on the edge that would capture HALT at pc 0xA.
        mem[5] = HALT_WORD;
        cycle();
        check("T4 pre", 32'(bus.imem_pc_po), 32'h000A);
        drive(1'b0, 1'b1, 1'b1, 16'h0020); cycle();
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        check("T4 no halt", 32'(bus.halted_po), 32'h0);
        check("T4 target", 32'(bus.imem_pc_po), 32'h0020);
        cycle();
        check("T4 resumed", 32'(bus.instr_pc_po), 32'h0020);
        mem[5] = 16'h0005;

        // T5: sequential wrap from 0xFFFE.
        drive(1'b0, 1'b1, 1'b1, 16'hFFFE); cycle();
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        check("T5 at top", 32'(bus.imem_pc_po), 32'hFFFE);
        cycle();
        check("T5 captured", 32'(bus.instr_pc_po), 32'hFFFE);
        check("T5 wrapped", 32'(bus.imem_pc_po), 32'h0000);

        // T6: reset with the slot occupied, then restart from RESET_PC.
        rst = 1'b1; cycle(); rst = 1'b0;
        check("T6 valid", 32'(bus.instr_valid_po), 32'h0);
        check("T6 pc", 32'(bus.imem_pc_po), 32'(RESET_PC));
        cycle();
        check("T6 idle", 32'(bus.instr_valid_po), 32'h0);
        drive(1'b1, 1'b1, 1'b0, 16'h0); cycle();
        drive(1'b0, 1'b1, 1'b0, 16'h0); cycle();
        check("T6 refetch", 32'(bus.instr_pc_po), 32'(RESET_PC));
        check("T6 refetch valid", 32'(bus.instr_valid_po), 32'h1);

        // Randomised traffic against the model.
        for (int i = 0; i < 32768; i++)
            mem[i] = ($urandom_range(0, 63) == 0) ? HALT_WORD : 16'($urandom_range(0, 32'hFFFE));
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 299) == 0) ||
                  (m_halted && !m_v && $urandom_range(0, 3) == 0);
            drive(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0), 16'($urandom));
            cycle();
        end
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 16'h0);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
